// File: rtl/tartaruga_pkg.sv
// -----------------------------------------------------------------------------
// tartaruga_pkg
//   Shared core types for the store buffer.
//   - sb_state_t         : per-entry lifecycle (FREE -> ALLOC -> COMMITTED -> FREE)
//   - sb_entry_t         : one store entry at the core's native XLEN widths
//   - store_buffer_idx_t : entry index for the core-level STORE_BUFFER_SIZE
//   - sb_is_live()       : true for any entry that still holds a store
// -----------------------------------------------------------------------------
package tartaruga_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned STORE_BUFFER_SIZE = 4;

  typedef logic [$clog2(STORE_BUFFER_SIZE)-1:0] store_buffer_idx_t;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_ALLOC     = 2'd1,
    SB_COMMITTED = 2'd2
  } sb_state_t;

  typedef struct packed {
    sb_state_t             state;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       data;
    logic [XLEN/8-1:0]     be;
  } sb_entry_t;

  function automatic logic sb_is_live(input sb_state_t s);
    return s != SB_FREE;
  endfunction

endpackage : tartaruga_pkg

// File: rtl/store_buffer_fwd.sv
// -----------------------------------------------------------------------------
// store_buffer_fwd
//   Combinational load-forwarding search. Compares the load word address
//   against every live entry and returns the youngest match.
//   Ports:
//     head_i     : index of the oldest entry
//     state_i    : per-entry state
//     addr_i / data_i / be_i : per-entry payload
//     ld_addr_i  : load address (only the word address is compared)
//     ld_hit_o / ld_data_o / ld_be_o : forwarding result
// -----------------------------------------------------------------------------
module store_buffer_fwd
  import tartaruga_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(DEPTH),
  localparam int unsigned BE_W   = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(BE_W)
) (
  input  logic [IDX_W-1:0]  head_i,
  input  sb_state_t         state_i [DEPTH],
  input  logic [ADDR_W-1:0] addr_i  [DEPTH],
  input  logic [DATA_W-1:0] data_i  [DEPTH],
  input  logic [BE_W-1:0]   be_i    [DEPTH],
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [BE_W-1:0]   ld_be_o
);

  logic [IDX_W-1:0] idx;

  // Live entries are contiguous from head, so walking oldest to youngest and
  // letting each later match overwrite the result leaves the youngest one.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    ld_be_o   = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + IDX_W'(i);
      if (sb_is_live(state_i[idx]) &&
          addr_i[idx][ADDR_W-1:OFF_W] == ld_addr_i[ADDR_W-1:OFF_W]) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_i[idx];
        ld_be_o   = be_i[idx];
      end
    end
  end

  // Byte-offset bits do not take part in the word compare.
  if (OFF_W > 0) begin : g_lo
    logic unused_lo;
    always_comb begin
      unused_lo = ^ld_addr_i[OFF_W-1:0];
      for (int i = 0; i < DEPTH; i++) begin
        unused_lo = unused_lo ^ (^addr_i[i][OFF_W-1:0]);
      end
    end
  end

endmodule : store_buffer_fwd

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Circular buffer of stores between the MEM stage and the data memory.
//   Stores are allocated at tail, committed by the ROB in order, and drained
//   from head to memory once committed. A flush drops uncommitted entries.
//   Optional feature: define STORE_BUFFER_FWD_EN to enable load forwarding;
//   otherwise the ld_* outputs are tied to zero.
//   Ports:
//     clk_i, rst_i            : clock, synchronous active-high reset
//     alloc_*                 : new store in, ready/index out
//     commit_valid_i/idx_i    : ROB commit of one entry
//     flush_i                 : discard all uncommitted entries
//     mem_*                   : data-memory write port (req/gnt handshake)
//     ld_addr_i, ld_*_o       : load forwarding port
//     count_o, empty_o        : occupancy
// -----------------------------------------------------------------------------
module store_buffer
  import tartaruga_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(DEPTH),
  localparam int unsigned BE_W   = DATA_W / 8,
  localparam int unsigned CNT_W  = IDX_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_valid_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic [DATA_W-1:0] alloc_data_i,
  input  logic [BE_W-1:0]   alloc_be_i,
  output logic              alloc_ready_o,
  output logic [IDX_W-1:0]  alloc_idx_o,
  input  logic              commit_valid_i,
  input  logic [IDX_W-1:0]  commit_idx_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [BE_W-1:0]   mem_be_o,
  input  logic              mem_gnt_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [BE_W-1:0]   ld_be_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  sb_state_t         state_q [DEPTH];
  sb_state_t         state_c [DEPTH];
  sb_state_t         state_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_committed;

  logic alloc_fire;
  logic drain;

  assign alloc_ready_o = count_q < CNT_W'(DEPTH);
  assign alloc_idx_o   = tail_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o && !flush_i;

  assign mem_req_o  = state_q[head_q] == SB_COMMITTED;
  assign drain      = mem_req_o && mem_gnt_i;
  // Payload is gated so the port reads zero whenever no request is pending.
  assign mem_addr_o = mem_req_o ? addr_q[head_q] : '0;
  assign mem_data_o = mem_req_o ? data_q[head_q] : '0;
  assign mem_be_o   = mem_req_o ? be_q[head_q]   : '0;

  assign count_o = count_q;
  assign empty_o = count_q == '0;

  // Commit is applied first so a same-cycle flush sees the entry as COMMITTED.
  always_comb begin
    state_c = state_q;
    if (commit_valid_i && state_q[commit_idx_i] == SB_ALLOC) begin
      state_c[commit_idx_i] = SB_COMMITTED;
    end

    n_committed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_c[i] == SB_COMMITTED) n_committed = n_committed + CNT_W'(1);
    end

    state_d = state_c;
    if (drain) state_d[head_q] = SB_FREE;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_d[i] == SB_ALLOC) state_d[i] = SB_FREE;
      end
    end
    if (alloc_fire) state_d[tail_q] = SB_ALLOC;

    head_d = drain ? head_q + IDX_W'(1) : head_q;

    if (flush_i) begin
      // Committed entries sit contiguously from head; a full committed buffer
      // wraps tail back onto head, which is the correct full state.
      tail_d  = head_q + n_committed[IDX_W-1:0];
      count_d = drain ? n_committed - CNT_W'(1) : n_committed;
    end else begin
      tail_d  = alloc_fire ? tail_q + IDX_W'(1) : tail_q;
      count_d = count_q;
      if (alloc_fire) count_d = count_d + CNT_W'(1);
      if (drain)      count_d = count_d - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) state_q[i] <= SB_FREE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // NOTE: payload storage has no reset; an entry's contents are only observed
  // while its state is non-FREE, and the state array is reset.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      addr_q[tail_q] <= alloc_addr_i;
      data_q[tail_q] <= alloc_data_i;
      be_q[tail_q]   <= alloc_be_i;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  store_buffer_fwd #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .head_i    (head_q),
    .state_i   (state_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .be_i      (be_q),
    .ld_addr_i (ld_addr_i),
    .ld_hit_o  (ld_hit_o),
    .ld_data_o (ld_data_o),
    .ld_be_o   (ld_be_o)
  );
`else
  assign ld_hit_o  = 1'b0;
  assign ld_data_o = '0;
  assign ld_be_o   = '0;

  logic unused_ld;
  assign unused_ld = ^ld_addr_i;
`endif

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed self-checking bench for store_buffer (DEPTH=4, 32-bit addr/data).
//   Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int IDX_W = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i;
  logic [31:0] alloc_addr_i;
  logic [31:0] alloc_data_i;
  logic [3:0]  alloc_be_i;
  logic        alloc_ready_o;
  logic [1:0]  alloc_idx_o;
  logic        commit_valid_i;
  logic [1:0]  commit_idx_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic [3:0]  ld_be_o;
  logic [2:0]  count_o;
  logic        empty_o;

  int errors = 0;
  int checks = 0;

  store_buffer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_addr_i   (alloc_addr_i),
    .alloc_data_i   (alloc_data_i),
    .alloc_be_i     (alloc_be_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_idx_o    (alloc_idx_o),
    .commit_valid_i (commit_valid_i),
    .commit_idx_i   (commit_idx_i),
    .flush_i        (flush_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_be_o       (mem_be_o),
    .mem_gnt_i      (mem_gnt_i),
    .ld_addr_i      (ld_addr_i),
    .ld_hit_o       (ld_hit_o),
    .ld_data_o      (ld_data_o),
    .ld_be_o        (ld_be_o),
    .count_o        (count_o),
    .empty_o        (empty_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid_i  = 1'b0;
    alloc_addr_i   = '0;
    alloc_data_i   = '0;
    alloc_be_i     = '0;
    commit_valid_i = 1'b0;
    commit_idx_i   = '0;
    flush_i        = 1'b0;
    mem_gnt_i      = 1'b0;
    ld_addr_i      = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = a;
    alloc_data_i  = d;
    alloc_be_i    = be;
  endtask

  // Reset must clear state even with a pending request and a commit in flight.
  task automatic test_reset();
    reset_dut();
    alloc(32'h0000_0050, 32'hCAFE_F00D, 4'hF);
    tick();
    alloc_valid_i  = 1'b0;
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    tick();
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++; $display("FAIL reset_pre_req: got %b expected 1", mem_req_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    commit_valid_i = 1'b0;
    checks++;
    if ({alloc_ready_o, alloc_idx_o, mem_req_o, count_o, empty_o} !== {1'b1, 2'd0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b idx=%0d req=%b cnt=%0d empty=%b expected rdy=1 idx=0 req=0 cnt=0 empty=1",
               alloc_ready_o, alloc_idx_o, mem_req_o, count_o, empty_o);
    end
    checks++;
    if ({mem_addr_o, mem_data_o, mem_be_o} !== 68'h0) begin
      errors++;
      $display("FAIL reset_mem: got addr=%h data=%h be=%h expected all zero", mem_addr_o, mem_data_o, mem_be_o);
    end
    checks++;
    if ({ld_hit_o, ld_data_o, ld_be_o} !== 37'h0) begin
      errors++;
      $display("FAIL reset_ld: got hit=%b data=%h be=%h expected all zero", ld_hit_o, ld_data_o, ld_be_o);
    end
  endtask

  task automatic test_basic();
    reset_dut();
    alloc(32'h0000_0100, 32'hAABB_CCDD, 4'hF);
    checks++;
    if (alloc_idx_o !== 2'd0 || alloc_ready_o !== 1'b1) begin
      errors++; $display("FAIL basic_alloc_idx: got idx=%0d rdy=%b expected idx=0 rdy=1", alloc_idx_o, alloc_ready_o);
    end
    tick();
    alloc_valid_i = 1'b0;
    checks++;
    if (count_o !== 3'd1 || empty_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL basic_after_alloc: got cnt=%0d empty=%b req=%b expected cnt=1 empty=0 req=0",
                         count_o, empty_o, mem_req_o);
    end
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    mem_gnt_i      = 1'b1;
    tick();
    commit_valid_i = 1'b0;
    checks++;
    if ({mem_req_o, mem_addr_o, mem_data_o, mem_be_o} !== {1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'hF}) begin
      errors++; $display("FAIL basic_req: got req=%b addr=%h data=%h be=%h expected req=1 addr=00000100 data=aabbccdd be=f",
                         mem_req_o, mem_addr_o, mem_data_o, mem_be_o);
    end
    tick();
    mem_gnt_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL basic_drained: got req=%b empty=%b expected req=0 empty=1", mem_req_o, empty_o);
    end
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      alloc(32'h0000_0400 + 32'(4 * i), 32'(i), 4'hF);
      checks++;
      if (alloc_idx_o !== IDX_W'(i)) begin
        errors++; $display("FAIL full_alloc_idx: got %0d expected %0d", alloc_idx_o, i);
      end
      tick();
    end
    alloc_valid_i = 1'b0;
    checks++;
    if (alloc_ready_o !== 1'b0 || count_o !== 3'd4) begin
      errors++; $display("FAIL full_state: got rdy=%b cnt=%0d expected rdy=0 cnt=4", alloc_ready_o, count_o);
    end
    alloc(32'h0000_0999, 32'hDEAD_BEEF, 4'hF);
    tick();
    alloc_valid_i = 1'b0;
    checks++;
    if (count_o !== 3'd4 || alloc_idx_o !== 2'd0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL full_fifth_ignored: got cnt=%0d idx=%0d req=%b expected cnt=4 idx=0 req=0",
                         count_o, alloc_idx_o, mem_req_o);
    end
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    mem_gnt_i      = 1'b1;
    tick();
    commit_valid_i = 1'b0;
    checks++;
    if (alloc_ready_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0400) begin
      errors++; $display("FAIL full_draining: got rdy=%b req=%b addr=%h expected rdy=0 req=1 addr=00000400",
                         alloc_ready_o, mem_req_o, mem_addr_o);
    end
    tick();
    mem_gnt_i = 1'b0;
    checks++;
    if (alloc_ready_o !== 1'b1 || count_o !== 3'd3 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL full_freed: got rdy=%b cnt=%0d req=%b expected rdy=1 cnt=3 req=0",
                         alloc_ready_o, count_o, mem_req_o);
    end
  endtask

  task automatic test_flush();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      alloc(32'h0000_0500 + 32'(4 * i), 32'h5500 + 32'(i), 4'hF);
      tick();
    end
    alloc_valid_i  = 1'b0;
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    tick();
    commit_valid_i = 1'b0;
    flush_i        = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (count_o !== 3'd1 || alloc_idx_o !== 2'd1) begin
      errors++; $display("FAIL flush_count_tail: got cnt=%0d idx=%0d expected cnt=1 idx=1", count_o, alloc_idx_o);
    end
    checks++;
    if (mem_req_o !== 1'b1 || mem_data_o !== 32'h0000_5500) begin
      errors++; $display("FAIL flush_committed_kept: got req=%b data=%h expected req=1 data=00005500", mem_req_o, mem_data_o);
    end
    alloc(32'h0000_05F0, 32'h0000_55F0, 4'hF);
    checks++;
    if (alloc_idx_o !== 2'd1) begin
      errors++; $display("FAIL flush_next_idx: got %0d expected 1", alloc_idx_o);
    end
    tick();
    alloc_valid_i = 1'b0;
    checks++;
    if (count_o !== 3'd2) begin
      errors++; $display("FAIL flush_realloc_count: got %0d expected 2", count_o);
    end
  endtask

  // Commit and flush in the same cycle: commit wins; the same-cycle alloc drops.
  task automatic test_commit_flush();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      alloc(32'h0000_0700 + 32'(4 * i), 32'h7700 + 32'(i), 4'hF);
      tick();
    end
    alloc(32'h0000_0777, 32'h0000_7777, 4'hF);
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    flush_i        = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (count_o !== 3'd1 || alloc_idx_o !== 2'd1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0700) begin
      errors++; $display("FAIL commit_flush: got cnt=%0d idx=%0d req=%b addr=%h expected cnt=1 idx=1 req=1 addr=00000700",
                         count_o, alloc_idx_o, mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_hold();
    reset_dut();
    alloc(32'h0000_0300, 32'h1234_5678, 4'h3);
    tick();
    alloc(32'h0000_0304, 32'h9ABC_DEF0, 4'hC);
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    tick();
    alloc_valid_i = 1'b0;
    commit_idx_i  = 2'd1;
    tick();
    commit_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({mem_req_o, mem_addr_o, mem_data_o, mem_be_o} !== {1'b1, 32'h0000_0300, 32'h1234_5678, 4'h3}) begin
        errors++; $display("FAIL hold_cycle%0d: got req=%b addr=%h data=%h be=%h expected req=1 addr=00000300 data=12345678 be=3",
                           c, mem_req_o, mem_addr_o, mem_data_o, mem_be_o);
      end
      tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    checks++;
    if ({mem_req_o, mem_addr_o, mem_data_o, mem_be_o, count_o} !== {1'b1, 32'h0000_0304, 32'h9ABC_DEF0, 4'hC, 3'd1}) begin
      errors++; $display("FAIL hold_advance: got req=%b addr=%h data=%h be=%h cnt=%0d expected req=1 addr=00000304 data=9abcdef0 be=c cnt=1",
                         mem_req_o, mem_addr_o, mem_data_o, mem_be_o, count_o);
    end
  endtask

  task automatic test_fwd();
    reset_dut();
    alloc(32'h0000_0200, 32'h0000_0011, 4'h1);
    tick();
    alloc(32'h0000_0200, 32'h0000_0022, 4'h1);
    tick();
    alloc_valid_i = 1'b0;
    ld_addr_i     = 32'h0000_0200;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    checks++;
    if ({ld_hit_o, ld_data_o, ld_be_o} !== {1'b1, 32'h0000_0022, 4'h1}) begin
      errors++; $display("FAIL fwd_youngest: got hit=%b data=%h be=%h expected hit=1 data=00000022 be=1",
                         ld_hit_o, ld_data_o, ld_be_o);
    end
    ld_addr_i = 32'h0000_0202;
    #1;
    checks++;
    if (ld_hit_o !== 1'b1 || ld_data_o !== 32'h0000_0022) begin
      errors++; $display("FAIL fwd_same_word: got hit=%b data=%h expected hit=1 data=00000022", ld_hit_o, ld_data_o);
    end
    ld_addr_i = 32'h0000_0204;
    #1;
    checks++;
    if (ld_hit_o !== 1'b0) begin
      errors++; $display("FAIL fwd_miss: got hit=%b expected 0", ld_hit_o);
    end
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    tick();
    commit_valid_i = 1'b0;
    flush_i        = 1'b1;
    tick();
    flush_i   = 1'b0;
    ld_addr_i = 32'h0000_0200;
    #1;
    checks++;
    if (ld_hit_o !== 1'b1 || ld_data_o !== 32'h0000_0011) begin
      errors++; $display("FAIL fwd_after_flush: got hit=%b data=%h expected hit=1 data=00000011", ld_hit_o, ld_data_o);
    end
`else
    checks++;
    if ({ld_hit_o, ld_data_o, ld_be_o} !== 37'h0) begin
      errors++; $display("FAIL fwd_disabled: got hit=%b data=%h be=%h expected all zero", ld_hit_o, ld_data_o, ld_be_o);
    end
`endif
    ld_addr_i = '0;
  endtask

  // Alloc, commit and drain all in one cycle.
  task automatic test_back_to_back();
    reset_dut();
    alloc(32'h0000_0600, 32'h0000_00A0, 4'hF);
    tick();
    alloc(32'h0000_0604, 32'h0000_00A1, 4'hF);
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    tick();
    checks++;
    if (count_o !== 3'd2 || mem_req_o !== 1'b1 || mem_data_o !== 32'h0000_00A0) begin
      errors++; $display("FAIL b2b_setup: got cnt=%0d req=%b data=%h expected cnt=2 req=1 data=000000a0",
                         count_o, mem_req_o, mem_data_o);
    end
    alloc(32'h0000_0608, 32'h0000_00A2, 4'hF);
    commit_idx_i = 2'd1;
    mem_gnt_i    = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (count_o !== 3'd2 || alloc_idx_o !== 2'd3 || mem_req_o !== 1'b1 || mem_data_o !== 32'h0000_00A1) begin
      errors++; $display("FAIL b2b_all: got cnt=%0d idx=%0d req=%b data=%h expected cnt=2 idx=3 req=1 data=000000a1",
                         count_o, alloc_idx_o, mem_req_o, mem_data_o);
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      alloc(32'h0000_1000 + 32'(4 * k), 32'hD000_0000 + 32'(k), 4'hF);
      checks++;
      if (alloc_idx_o !== IDX_W'(k % DEPTH)) begin
        errors++; $display("FAIL wrap_idx%0d: got %0d expected %0d", k, alloc_idx_o, k % DEPTH);
      end
      tick();
      alloc_valid_i  = 1'b0;
      commit_valid_i = 1'b1;
      commit_idx_i   = IDX_W'(k % DEPTH);
      mem_gnt_i      = 1'b1;
      tick();
      commit_valid_i = 1'b0;
      checks++;
      if (mem_req_o !== 1'b1 || mem_data_o !== 32'hD000_0000 + 32'(k)) begin
        errors++; $display("FAIL wrap_data%0d: got req=%b data=%h expected req=1 data=%h",
                           k, mem_req_o, mem_data_o, 32'hD000_0000 + 32'(k));
      end
      tick();
      mem_gnt_i = 1'b0;
      checks++;
      if (empty_o !== 1'b1) begin
        errors++; $display("FAIL wrap_empty%0d: got %b expected 1", k, empty_o);
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_commit_flush();
    test_hold();
    test_fwd();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_store_buffer
